// File: rtl/fir2d_pkg.sv
// Shared constants and helpers for the 5x5 2D FIR convolution path.
// Widths:
//   PIX_W   unsigned pixel width
//   COEFF_W signed coefficient width, Q(COEFF_W-SHIFT).SHIFT
//   PROD_W  one pixel x coefficient product (pixel zero-extended, signed)
//   ROW_W   sum of one 5-tap row
//   ACC_W   full 25-tap accumulator
// saturate() clamps a signed accumulator-width value to [0, 2^PIX_W-1];
// the coefficient stage can reuse it.
package fir2d_pkg;
  localparam int PIX_W   = 8;
  localparam int COEFF_W = 16;
  localparam int SHIFT   = 8;
  localparam int TAPS    = 5;
  localparam int LATENCY = 5;
  localparam int PROD_W  = PIX_W + COEFF_W + 1;
  localparam int ROW_W   = PROD_W + 3;
  localparam int ACC_W   = PIX_W + COEFF_W + 6;

  function automatic logic [PIX_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    if (v[ACC_W-1])                 return '0;  // negative
    else if (|v[ACC_W-2:PIX_W])     return '1;  // above full scale
    else                            return v[PIX_W-1:0];
  endfunction
endpackage

// File: rtl/fir2d_row5.sv
// One window row times its 5 coefficients: registered products (S2) and
// registered row sum (S3).
// Ports:
//   clk     system clock
//   rst     synchronous reset, active low
//   pix_i   5 row pixels, element 0 = newest column
//   coeff_i 5 signed coefficients, element c matches pix_i[c]
//   sum_o   registered signed row sum
module fir2d_row5
  import fir2d_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst,
  input  logic [TAPS-1:0][PIX_W-1:0]         pix_i,
  input  logic [TAPS-1:0][COEFF_W-1:0]       coeff_i,
  output logic signed [ROW_W-1:0]            sum_o
);
  logic signed [PROD_W-1:0] prod_q [TAPS];
  logic signed [ROW_W-1:0]  sum_d, sum_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < TAPS; c++) prod_q[c] <= '0;
    end else begin
      // Pixel zero-extended by one bit so it multiplies as a positive signed value.
      for (int c = 0; c < TAPS; c++)
        prod_q[c] <= PROD_W'($signed({1'b0, pix_i[c]})) * PROD_W'($signed(coeff_i[c]));
    end
  end

  always_comb begin
    sum_d = '0;
    for (int c = 0; c < TAPS; c++) sum_d = sum_d + ROW_W'(prod_q[c]);
  end

  always_ff @(posedge clk) begin
    if (!rst) sum_q <= '0;
    else      sum_q <= sum_d;
  end

  assign sum_o = sum_q;
endmodule

// File: rtl/fir2d_conv5x5.sv
// 5x5 2D FIR convolution core. Builds a 5x5 window from one vertical
// column per clock, convolves it with 25 signed coefficients and emits one
// saturated pixel per input pixel, with video timing delayed to match.
// Pipeline: S1 window, S2 products, S3 row sums, S4 total, S5 shift+clamp.
// Ports:
//   clk      system clock
//   rst      synchronous reset, active low
//   vs_i/hs_i/de_i  video timing in; de_i qualifies col_i
//   col_i    column, row r at [r*PIX_W +: PIX_W], r=0 oldest line
//   coeff_i  coeffRC at [(5*R+C)*COEFF_W +: COEFF_W], C=0 newest column
//   pixel_o  filtered pixel, 0 when de_o is 0
//   vs_o/hs_o/de_o  inputs delayed by LATENCY
// Build option: FIR2D_ROUND_EN adds 2^(SHIFT-1) before the shift (round
// half up); otherwise the shift truncates toward -inf.
module fir2d_conv5x5
  import fir2d_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            vs_i,
  input  logic                            hs_i,
  input  logic                            de_i,
  input  logic [TAPS*PIX_W-1:0]           col_i,
  input  logic [TAPS*TAPS*COEFF_W-1:0]    coeff_i,
  output logic [PIX_W-1:0]                pixel_o,
  output logic                            vs_o,
  output logic                            hs_o,
  output logic                            de_o
);
  // S1: win_q[r][c], c=0 newest column. A gap in de_i clears the window so
  // each run of valid columns starts with zero padding.
  logic [TAPS-1:0][TAPS-1:0][PIX_W-1:0] win_q, win_d;

  always_comb begin
    win_d = '0;
    if (de_i) begin
      for (int r = 0; r < TAPS; r++) begin
        win_d[r][0] = col_i[r*PIX_W +: PIX_W];
        for (int c = 1; c < TAPS; c++) win_d[r][c] = win_q[r][c-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) win_q <= '0;
    else      win_q <= win_d;
  end

  // S2-S3: one row engine per window row; coeff_i is used live, no copy.
  logic signed [ROW_W-1:0] row_sum [TAPS];

  for (genvar r = 0; r < TAPS; r++) begin : g_row
    fir2d_row5 u_row (
      .clk     (clk),
      .rst     (rst),
      .pix_i   (win_q[r]),
      .coeff_i (coeff_i[r*TAPS*COEFF_W +: TAPS*COEFF_W]),
      .sum_o   (row_sum[r])
    );
  end

  // S4: total sum.
  logic signed [ACC_W-1:0] acc_d, acc_q;

  always_comb begin
    acc_d = '0;
    for (int r = 0; r < TAPS; r++) acc_d = acc_d + ACC_W'(row_sum[r]);
  end

  always_ff @(posedge clk) begin
    if (!rst) acc_q <= '0;
    else      acc_q <= acc_d;
  end

  // S5: optional rounding, arithmetic shift, clamp.
  logic signed [ACC_W-1:0] acc_rnd, acc_shf;

`ifdef FIR2D_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) <<< (SHIFT-1);
  assign acc_rnd = acc_q + RND;
`else
  assign acc_rnd = acc_q;
`endif
  assign acc_shf = acc_rnd >>> SHIFT;

  // Timing delay line; bit LATENCY-2 lines up with the S4 result.
  logic [LATENCY-1:0] vs_q, hs_q, de_q;
  logic [PIX_W-1:0]   pix_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      vs_q  <= '0;
      hs_q  <= '0;
      de_q  <= '0;
      pix_q <= '0;
    end else begin
      vs_q  <= {vs_q[LATENCY-2:0], vs_i};
      hs_q  <= {hs_q[LATENCY-2:0], hs_i};
      de_q  <= {de_q[LATENCY-2:0], de_i};
      pix_q <= de_q[LATENCY-2] ? saturate(acc_shf) : '0;
    end
  end

  assign pixel_o = pix_q;
  assign vs_o    = vs_q[LATENCY-1];
  assign hs_o    = hs_q[LATENCY-1];
  assign de_o    = de_q[LATENCY-1];
endmodule

// File: tb/tb_fir2d_conv5x5.sv
module tb_fir2d_conv5x5;
  logic         clk = 1'b0;
  logic         rst;
  logic         vs_i, hs_i, de_i;
  logic [39:0]  col_i;
  logic [399:0] coeff_i;
  logic [7:0]   pixel_o;
  logic         vs_o, hs_o, de_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  fir2d_conv5x5 dut (
    .clk(clk), .rst(rst), .vs_i(vs_i), .hs_i(hs_i), .de_i(de_i),
    .col_i(col_i), .coeff_i(coeff_i), .pixel_o(pixel_o),
    .vs_o(vs_o), .hs_o(hs_o), .de_o(de_o)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] mk_col(input logic [7:0] r0, r1, r2, r3, r4);
    return {r4, r3, r2, r1, r0};
  endfunction

  task automatic drive(input logic de, input logic vs, input logic hs, input logic [39:0] col);
    de_i = de; vs_i = vs; hs_i = hs; col_i = col;
    @(posedge clk); #1;
  endtask

  task automatic flush();
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b0, 40'd0);
  endtask

  task automatic set_coeff(input int idx, input logic [15:0] v);
    coeff_i[idx*16 +: 16] = v;
  endtask

  task automatic test_reset();
    rst = 1'b0; de_i = 1'b1; vs_i = 1'b1; hs_i = 1'b1;
    col_i = {5{8'hFF}};
    coeff_i = '0; set_coeff(12, 16'd256);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total_cnt++;
      if ({pixel_o, vs_o, hs_o, de_o} !== 11'd0)
        $display("FAIL reset_hold cyc %0d: got pix=%0d vs=%b hs=%b de=%b expected all 0", i, pixel_o, vs_o, hs_o, de_o);
      else pass_cnt++;
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 40'd0);
      total_cnt++;
      if ({pixel_o, vs_o, hs_o, de_o} !== 11'd0)
        $display("FAIL reset_release cyc %0d: got pix=%0d vs=%b hs=%b de=%b expected all 0", i, pixel_o, vs_o, hs_o, de_o);
      else pass_cnt++;
    end
    // Reset mid-stream: in-flight pixels must vanish.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, {5{8'hFF}});
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 40'd0);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 1'b0, 40'd0);
      total_cnt++;
      if ({pixel_o, vs_o, hs_o, de_o} !== 11'd0)
        $display("FAIL reset_midframe cyc %0d: got pix=%0d vs=%b hs=%b de=%b expected all 0", i, pixel_o, vs_o, hs_o, de_o);
      else pass_cnt++;
    end
  endtask

  // Centre tap 1.0, ramp 10,11,.. on the centre row; other rows ignored.
  task automatic test_ramp();
    int n = 8;
    logic  exp_de;
    int    exp_pix;
    coeff_i = '0; set_coeff(12, 16'd256);
    flush();
    for (int i = 0; i < n + 4; i++) begin
      if (i < n) drive(1'b1, 1'b0, 1'b1, mk_col(8'd77, 8'd77, 8'(10 + i), 8'd77, 8'd77));
      else       drive(1'b0, 1'b0, 1'b0, 40'd0);
      exp_de  = (i >= 4) && (i - 4 < n);
      exp_pix = !exp_de ? 0 : ((i - 4) < 2 ? 0 : 10 + (i - 4) - 2);
      total_cnt++;
      if (de_o !== exp_de) $display("FAIL ramp_de i=%0d: got %b expected %b", i, de_o, exp_de);
      else pass_cnt++;
      total_cnt++;
      if (pixel_o !== 8'(exp_pix)) $display("FAIL ramp_pix i=%0d: got %0d expected %0d", i, pixel_o, exp_pix);
      else pass_cnt++;
    end
  endtask

  task automatic test_sat_high();
    coeff_i = {25{16'd256}};
    flush();
    for (int i = 0; i < 10; i++) begin
      if (i < 6) drive(1'b1, 1'b0, 1'b0, {5{8'hFF}});
      else       drive(1'b0, 1'b0, 1'b0, 40'd0);
      if (i >= 4) begin
        total_cnt++;
        if (pixel_o !== 8'd255 || de_o !== 1'b1)
          $display("FAIL sat_high i=%0d: got pix=%0d de=%b expected 255 de=1", i, pixel_o, de_o);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_sat_low();
    coeff_i = '0; set_coeff(12, 16'hFF00);
    flush();
    for (int i = 0; i < 9; i++) begin
      if (i < 5) drive(1'b1, 1'b0, 1'b0, {5{8'd100}});
      else       drive(1'b0, 1'b0, 1'b0, 40'd0);
      if (i >= 4) begin
        total_cnt++;
        if (pixel_o !== 8'd0 || de_o !== 1'b1)
          $display("FAIL sat_low i=%0d: got pix=%0d de=%b expected 0 de=1", i, pixel_o, de_o);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_rounding();
`ifdef FIR2D_ROUND_EN
    int exp_val = 2;
`else
    int exp_val = 1;
`endif
    int exp_pix;
    coeff_i = '0; set_coeff(12, 16'd128);
    flush();
    for (int i = 0; i < 9; i++) begin
      if (i < 5) drive(1'b1, 1'b0, 1'b0, {5{8'd3}});
      else       drive(1'b0, 1'b0, 1'b0, 40'd0);
      if (i >= 4) begin
        exp_pix = (i - 4) < 2 ? 0 : exp_val;
        total_cnt++;
        if (pixel_o !== 8'(exp_pix))
          $display("FAIL rounding i=%0d: got %0d expected %0d", i, pixel_o, exp_pix);
        else pass_cnt++;
      end
    end
  endtask

  // coeff R1C3 and R4C4 = 1.0; rows r carry 40*r + k + 1.
  task automatic test_taps();
    int n = 8;
    int j, exp_pix;
    coeff_i = '0; set_coeff(8, 16'd256); set_coeff(24, 16'd256);
    flush();
    for (int i = 0; i < n + 4; i++) begin
      if (i < n) drive(1'b1, 1'b0, 1'b0,
                       mk_col(8'(1 + i), 8'(41 + i), 8'(81 + i), 8'(121 + i), 8'(161 + i)));
      else       drive(1'b0, 1'b0, 1'b0, 40'd0);
      if (i >= 4) begin
        j = i - 4;
        exp_pix = (j < 3) ? 0 : (j == 3) ? 41 : 195 + 2 * j;
        total_cnt++;
        if (pixel_o !== 8'(exp_pix))
          $display("FAIL taps j=%0d: got %0d expected %0d", j, pixel_o, exp_pix);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_de_gap();
    logic [8:0] de_pat = 9'b111101111;  // bit k = sample k
    logic [8:0] vs_pat = 9'b101000110;
    logic [8:0] hs_pat = 9'b011011001;
    int exp_gap [9] = '{0, 0, 10, 11, 0, 0, 0, 15, 16};
    int n = 9;
    int j;
    logic e_de, e_vs, e_hs;
    coeff_i = '0; set_coeff(12, 16'd256);
    flush();
    for (int i = 0; i < n + 4; i++) begin
      if (i < n) drive(de_pat[i], vs_pat[i], hs_pat[i], mk_col(8'd5, 8'd5, 8'(10 + i), 8'd5, 8'd5));
      else       drive(1'b0, 1'b0, 1'b0, 40'd0);
      j = i - 4;
      e_de = (j >= 0) ? de_pat[j] : 1'b0;
      e_vs = (j >= 0) ? vs_pat[j] : 1'b0;
      e_hs = (j >= 0) ? hs_pat[j] : 1'b0;
      total_cnt++;
      if ({vs_o, hs_o, de_o} !== {e_vs, e_hs, e_de})
        $display("FAIL gap_timing i=%0d: got vs=%b hs=%b de=%b expected vs=%b hs=%b de=%b",
                 i, vs_o, hs_o, de_o, e_vs, e_hs, e_de);
      else pass_cnt++;
      if (j >= 0) begin
        total_cnt++;
        if (pixel_o !== 8'(exp_gap[j]))
          $display("FAIL gap_pix j=%0d: got %0d expected %0d", j, pixel_o, exp_gap[j]);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_sat_high();
    test_sat_low();
    test_rounding();
    test_taps();
    test_de_gap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
